// File: rtl/morse_pkg.sv
// morse_pkg: FSM state encoding, digit pattern constants and the
// pattern-to-digit lookup shared by the Morse key decoder files.
package morse_pkg;

  // Decoder FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS  = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_DECODE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  // Digit patterns: dot=0, dash=1, first symbol in the MSB
  localparam logic [4:0] PAT_DIGIT_1 = 5'b01111;
  localparam logic [4:0] PAT_DIGIT_2 = 5'b00111;
  localparam logic [4:0] PAT_DIGIT_3 = 5'b00011;
  localparam logic [4:0] PAT_DIGIT_4 = 5'b00001;
  localparam logic [4:0] PAT_DIGIT_5 = 5'b00000;
  localparam logic [4:0] PAT_DIGIT_6 = 5'b10000;
  localparam logic [4:0] PAT_DIGIT_7 = 5'b11000;
  localparam logic [4:0] PAT_DIGIT_8 = 5'b11100;
  localparam logic [4:0] PAT_DIGIT_9 = 5'b11110;
  localparam logic [4:0] PAT_DIGIT_0 = 5'b11111;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } morse_digit_t;

  // Map a complete 5-symbol pattern to its digit; anything else is invalid.
  function automatic morse_digit_t pattern_to_digit(input logic [4:0] pattern);
    morse_digit_t res;
    res.valid = 1'b1;
    case (pattern)
      PAT_DIGIT_1: res.digit = 4'd1;
      PAT_DIGIT_2: res.digit = 4'd2;
      PAT_DIGIT_3: res.digit = 4'd3;
      PAT_DIGIT_4: res.digit = 4'd4;
      PAT_DIGIT_5: res.digit = 4'd5;
      PAT_DIGIT_6: res.digit = 4'd6;
      PAT_DIGIT_7: res.digit = 4'd7;
      PAT_DIGIT_8: res.digit = 4'd8;
      PAT_DIGIT_9: res.digit = 4'd9;
      PAT_DIGIT_0: res.digit = 4'd0;
      default: begin
        res.valid = 1'b0;
        res.digit = 4'd0;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/morse_key_conditioner.sv
// morse_key_conditioner: brings the raw push-button into the clk domain with a
// 2-flop synchronizer. When MORSE_DEBOUNCE_EN is defined, a filter follows that
// only moves key_clean after DEBOUNCE_CYCLES consecutive cycles at a new level.
module morse_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_clean
);

  logic sync1_r;
  logic sync2_r;

  // Two-stage synchronizer for the asynchronous key input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int DBW = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(32'd1);

  logic [DBW-1:0] db_cnt_r;
  logic           clean_r;

  // Accept a new level only after it has been stable for the full filter depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_r <= '0;
      clean_r  <= 1'b0;
    end else if (sync2_r == clean_r) begin
      db_cnt_r <= '0;
    end else if (db_cnt_r == DB_LAST) begin
      clean_r  <= sync2_r;
      db_cnt_r <= '0;
    end else begin
      db_cnt_r <= db_cnt_r + DB_ONE;
    end
  end

  assign key_clean = clean_r;
`else
  // Filter depth has no effect in this build; no filter hardware is generated.
  if (DEBOUNCE_CYCLES != 32'd0) begin : g_filter_bypassed
  end

  assign key_clean = sync2_r;
`endif

endmodule

// File: rtl/morse_key_decoder.sv
// morse_key_decoder: times key presses into dots/dashes, collects five symbols
// and decodes them to a digit with a one-cycle load pulse (err on a bad pattern
// or an abandoned character). Optional input debounce: MORSE_DEBOUNCE_EN.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int unsigned DASH_THRESH     = 25_000_000,
  parameter int unsigned GAP_TIMEOUT     = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key,
  output logic [3:0] user_input,
  output logic       load,
  output logic       err,
  output logic [2:0] sym_count
);

  localparam int PCW = $clog2(DASH_THRESH + 32'd1);
  localparam int GCW = $clog2(GAP_TIMEOUT + 32'd1);
  localparam logic [PCW-1:0] DASH_MAX  = PCW'(DASH_THRESH);
  localparam logic [PCW-1:0] PRESS_ONE = PCW'(32'd1);
  localparam logic [GCW-1:0] GAP_MAX   = GCW'(GAP_TIMEOUT);
  localparam logic [GCW-1:0] GAP_ONE   = GCW'(32'd1);

  logic           ks_s;
  logic           ks_prev_r;
  logic           ks_rise_s;
  logic           ks_fall_s;
  logic           sym_s;
  morse_digit_t   decode_s;

  logic [2:0]     state_r;
  logic [PCW-1:0] press_cnt_r;
  logic [GCW-1:0] gap_cnt_r;
  logic [4:0]     pattern_r;
  logic [2:0]     sym_count_r;
  logic [3:0]     user_input_r;
  logic           load_r;
  logic           err_r;

  morse_key_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_conditioner (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key),
    .key_clean (ks_s)
  );

  // Edge detection on the conditioned key, symbol classification and lookup
  always_comb begin
    ks_rise_s = ks_s & ~ks_prev_r;
    ks_fall_s = ~ks_s & ks_prev_r;
    sym_s     = (press_cnt_r >= DASH_MAX);
    decode_s  = pattern_to_digit(pattern_r);
  end

  // Decoder FSM with its counters, pattern shift register and output pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ks_prev_r    <= 1'b0;
      state_r      <= ST_IDLE;
      press_cnt_r  <= '0;
      gap_cnt_r    <= '0;
      pattern_r    <= 5'd0;
      sym_count_r  <= 3'd0;
      user_input_r <= 4'd0;
      load_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      ks_prev_r <= ks_s;
      load_r    <= 1'b0;
      err_r     <= 1'b0;
      if (!enable) begin
        // Disabled: abandon everything silently
        state_r     <= ST_IDLE;
        press_cnt_r <= '0;
        gap_cnt_r   <= '0;
        pattern_r   <= 5'd0;
        sym_count_r <= 3'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (ks_rise_s) begin
              state_r     <= ST_PRESS;
              press_cnt_r <= '0;
            end
          end
          ST_PRESS: begin
            if (ks_fall_s) begin
              pattern_r   <= {pattern_r[3:0], sym_s};
              sym_count_r <= sym_count_r + 3'd1;
              if (sym_count_r == 3'd4) begin
                state_r <= ST_DECODE;
              end else begin
                state_r   <= ST_GAP;
                gap_cnt_r <= '0;
              end
            end else if (press_cnt_r != DASH_MAX) begin
              press_cnt_r <= press_cnt_r + PRESS_ONE;
            end
          end
          ST_GAP: begin
            // A new press wins over a coincident timeout
            if (ks_rise_s) begin
              state_r     <= ST_PRESS;
              press_cnt_r <= '0;
            end else if (gap_cnt_r == GAP_MAX) begin
              state_r <= ST_ERROR;
            end else begin
              gap_cnt_r <= gap_cnt_r + GAP_ONE;
            end
          end
          ST_DECODE: begin
            if (decode_s.valid) begin
              user_input_r <= decode_s.digit;
              load_r       <= 1'b1;
            end else begin
              err_r <= 1'b1;
            end
            pattern_r   <= 5'd0;
            sym_count_r <= 3'd0;
            state_r     <= ST_IDLE;
          end
          ST_ERROR: begin
            err_r       <= 1'b1;
            pattern_r   <= 5'd0;
            sym_count_r <= 3'd0;
            state_r     <= ST_IDLE;
          end
          default: begin
            pattern_r   <= 5'd0;
            sym_count_r <= 3'd0;
            state_r     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign user_input = user_input_r;
  assign load       = load_r;
  assign err        = err_r;
  assign sym_count  = sym_count_r;

endmodule

// File: doc/morse_key_decoder.md
MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

Interface
REQ-001 Parameter DASH_THRESH, 25_000_000, press length in cycles at or above which a symbol is a dash; below it the symbol is a dot.
REQ-002 Parameter GAP_TIMEOUT, 100_000_000, idle cycles after a release, mid-character, before the partial character is abandoned.
REQ-003 Parameter DEBOUNCE_CYCLES, 500_000, stable-level cycles required by the debounce filter (used only under MORSE_DEBOUNCE_EN).
REQ-004 Port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-low reset.
REQ-006 Port enable, input, 1, high while the game controller accepts answers; low aborts and blocks decoding.
REQ-007 Port key, input, 1, raw Morse push-button, asynchronous to clk, high while pressed.
REQ-008 Port user_input, output, 4, last decoded digit 0-9; held until the next load.
REQ-009 Port load, output, 1, single-cycle pulse marking user_input as newly valid.
REQ-010 Port err, output, 1, single-cycle pulse on an invalid pattern or gap timeout.
REQ-011 Port sym_count, output, 3, number of symbols captured in the current character (0-5), for display.

Function
REQ-012 key SHALL pass through a 2-flop synchronizer; all edge detection uses the synchronized level (ks).
REQ-013 FSM states SHALL be IDLE, PRESS, GAP, DECODE and ERROR.
REQ-014 IDLE: on a ks rising edge with enable=1, go to PRESS and clear the press counter.
REQ-015 PRESS: press counter SHALL increment each cycle and saturate at DASH_THRESH.
REQ-016 PRESS, on ks falling: sym = (count >= DASH_THRESH); pattern <= {pattern[3:0], sym}; sym_count++.
REQ-017 From PRESS, the next state SHALL be DECODE if sym_count reaches 5, else GAP with the gap counter cleared.
REQ-018 GAP: a ks rising edge SHALL go to PRESS.
REQ-019 GAP: the gap counter reaching GAP_TIMEOUT SHALL go to ERROR.
REQ-020 A ks rising edge and the timeout in the same cycle SHALL resolve to PRESS.
REQ-021 DECODE (one cycle) SHALL map the pattern 01111, 00111, 00011, 00001, 00000, 10000, 11000, 11100, 11110, 11111 to digits 1,2,3,4,5,6,7,8,9,0 respectively.
REQ-022 Pattern bits are dot=0 and dash=1, with the first symbol in the MSB.
REQ-023 A valid pattern SHALL register user_input and pulse load in the cycle after DECODE; the FSM then returns to IDLE.
REQ-024 Latency from the 5th synchronized release to load SHALL be exactly 2 cycles.
REQ-025 Any other pattern SHALL pulse err instead of load, leave user_input unchanged, and go to IDLE.
REQ-026 ERROR SHALL pulse err for one cycle, clear pattern and sym_count, and go to IDLE.
REQ-027 On leaving DECODE or ERROR, pattern and sym_count SHALL clear.
REQ-028 enable=0 in any state SHALL force IDLE next cycle and clear pattern, sym_count and counters, with no load or err.
REQ-029 A press already in progress when enable rises SHALL be ignored until the key is released.
REQ-030 load and err SHALL never both be high in the same cycle.

Reset
REQ-031 While rst=0: state=IDLE; user_input=0, load=0, err=0, sym_count=0; pattern, counters and synchronizer flops all 0.
REQ-032 Reset mid-character SHALL discard the character; the first press after reset release starts a new character.

Configuration
REQ-033 With MORSE_DEBOUNCE_EN defined, ks SHALL change only after the synchronized key has held a new level for DEBOUNCE_CYCLES consecutive cycles, adding that delay to all latencies.
REQ-034 Without MORSE_DEBOUNCE_EN, ks is the raw synchronizer output; DEBOUNCE_CYCLES is ignored and no filter logic is built.

Structure
REQ-035 Shared package morse_pkg SHALL hold the FSM state encoding, the ten 5-bit digit pattern constants, and the pattern-to-digit lookup function.
REQ-036 Synchronizer and debounce filter SHALL form sub-module morse_key_conditioner (ports clk, rst, key_raw, key_clean).

Verification (DASH_THRESH=8, GAP_TIMEOUT=32, DEBOUNCE_CYCLES=4)
REQ-037 Presses of 3,10,10,10,10 cycles with 5-cycle gaps -> single load pulse 2 cycles after the final release, user_input=1, sym_count 1..5 then 0.
REQ-038 Five 10-cycle presses -> user_input=0; then 3,3,3,3,10 -> user_input=4; no err.
REQ-039 Presses of 10,3,10,3,3 (pattern 10100) -> err pulse, no load, user_input keeps its prior value.
REQ-040 Two presses then 40 idle cycles -> err pulse at gap count 32, sym_count returns to 0, next full character decodes normally.
REQ-041 enable dropped after 3 symbols -> no load or err, sym_count=0; rst asserted mid-press -> all outputs 0 immediately.
REQ-042 With MORSE_DEBOUNCE_EN, 2-cycle glitches on key produce no symbol; without the macro the same glitch registers a dot.
